iter_divider: RTL and testbench

- Parametrised, iterative, multi-bit-per-cycle integer divider; successor to the single-mode start/ready divider.
- Adds:
  - synchronous reset
  - configurable radix (BITS_PER_CYCLE)
  - per-operation signed/unsigned mode
  - divide-by-zero and overflow flags
  - one-cycle result-valid strobe with back-to-back issue
- Used by the scanner's geometry/depth math wherever 36-bit signed quotients are needed.

---
 rtl/iter_divider.sv | 176 +++++++++++++++++
 tb/tb_iter_divider.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Iterative restoring integer divider with a selectable number of quotient
// bits per cycle. It supports signed and unsigned operation per request and
// flags divide-by-zero and signed overflow. It produces a one-cycle valid
// strobe and can accept a new request in that same cycle.
module iter_divider #(
  parameter int WIDTH          = 36,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qNeg_q, qNeg_d;
  logic             rNeg_q, rNeg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divZero_q, divZero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] dividendMag, dividerMag;
  logic [WIDTH-1:0] stepRem, stepQuo;

  // Operand magnitudes; the most-negative value maps onto 1<<(WIDTH-1) unsigned.
  always_comb begin
    dividendMag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    dividerMag  = (sign && divider[WIDTH-1])  ? -divider  : divider;
  end

  // Retire BITS_PER_CYCLE restoring-division steps. quo_q shifts dividend bits out MSB first and quotient bits in.
  always_comb begin
    logic [WIDTH:0] trial;
    stepRem = rem_q;
    stepQuo = quo_q;
    trial   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial   = {stepRem, stepQuo[WIDTH-1]};
      stepQuo = {stepQuo[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvsr_q}) begin
        trial      = trial - {1'b0, dvsr_q};
        stepQuo[0] = 1'b1;
      end
      stepRem = trial[WIDTH-1:0];
    end
  end

  // Next-state and datapath control for the IDLE -> RUN -> FIX sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    qNeg_d      = qNeg_q;
    rNeg_d      = rNeg_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    valid_d     = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divZero_d   = divZero_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          qNeg_d = sign & (dividend[WIDTH-1] ^ divider[WIDTH-1]);
          rNeg_d = sign & dividend[WIDTH-1];
          ovf_d  = sign && (dividend == MOST_NEG) && (divider == '1);
          dvsr_d = dividerMag;
          rem_d  = '0;
          if (divider == '0) begin
            dz_d    = 1'b1;
            quo_d   = dividend;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            quo_d   = dividendMag;
            cnt_d   = CNT_W'(ITER - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = stepRem;
        quo_d = stepQuo;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        valid_d = 1'b1;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
          divZero_d   = 1'b1;
          overflow_d  = 1'b0;
        end else begin
          quotient_d  = qNeg_q ? -quo_q : quo_q;
          remainder_d = rNeg_q ? -rem_q : rem_q;
          divZero_d   = 1'b0;
          overflow_d  = ovf_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      qNeg_q      <= 1'b0;
      rNeg_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      qNeg_q      <= qNeg_d;
      rNeg_q      <= rNeg_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divZero_q   <= divZero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign valid     = valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = divZero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider. It exercises three configurations:
// 36-bit radix-2, 8-bit radix-2 and 36-bit at four bits per cycle.
// All three share the clock, reset and operand buses, and each has its own start.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        sign;
  logic [35:0] dividend, divider;
  logic        startA, startB, startC;

  logic        readyA, validA, dzA, ovA;
  logic [35:0] quoA, remA;
  logic        readyB, validB, dzB, ovB;
  logic [7:0]  quoB, remB;
  logic        readyC, validC, dzC, ovC;
  logic [35:0] quoC, remC;

  int          sel;
  logic        obsReady, obsValid, obsDz, obsOv;
  logic [35:0] obsQ, obsR;

  int vectors     = 0;
  int miscompares = 0;

  iter_divider #(.WIDTH(36), .BITS_PER_CYCLE(1)) dutA (
    .clk(clk), .reset(reset), .start(startA), .sign(sign),
    .dividend(dividend), .divider(divider),
    .ready(readyA), .valid(validA), .quotient(quoA), .remainder(remA),
    .div_zero(dzA), .overflow(ovA)
  );

  iter_divider #(.WIDTH(8), .BITS_PER_CYCLE(1)) dutB (
    .clk(clk), .reset(reset), .start(startB), .sign(sign),
    .dividend(dividend[7:0]), .divider(divider[7:0]),
    .ready(readyB), .valid(validB), .quotient(quoB), .remainder(remB),
    .div_zero(dzB), .overflow(ovB)
  );

  iter_divider #(.WIDTH(36), .BITS_PER_CYCLE(4)) dutC (
    .clk(clk), .reset(reset), .start(startC), .sign(sign),
    .dividend(dividend), .divider(divider),
    .ready(readyC), .valid(validC), .quotient(quoC), .remainder(remC),
    .div_zero(dzC), .overflow(ovC)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Route the selected instance's outputs onto one set of observation wires.
  always_comb begin
    case (sel)
      1: begin
        obsReady = readyB; obsValid = validB; obsDz = dzB; obsOv = ovB;
        obsQ = {28'b0, quoB}; obsR = {28'b0, remB};
      end
      2: begin
        obsReady = readyC; obsValid = validC; obsDz = dzC; obsOv = ovC;
        obsQ = quoC; obsR = remC;
      end
      default: begin
        obsReady = readyA; obsValid = validA; obsDz = dzA; obsOv = ovA;
        obsQ = quoA; obsR = remA;
      end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [35:0] expQ, input logic [35:0] expR,
                             input logic expDz, input logic expOv);
    checkOutput({tag, "_quotient"}, obsQ, expQ);
    checkOutput({tag, "_remainder"}, obsR, expR);
    checkOutput({tag, "_divZero"}, 36'(obsDz), 36'(expDz));
    checkOutput({tag, "_overflow"}, 36'(obsOv), 36'(expOv));
  endtask

  // Present one request to the chosen instance for exactly one accepting edge.
  task automatic applyStimulus(input string tag, input int which, input logic s,
                               input logic [35:0] a, input logic [35:0] b);
    sel = which;
    sign = s;
    dividend = a;
    divider = b;
    #1;
    checkOutput({tag, "_readyAtIssue"}, 36'(obsReady), 36'd1);
    case (which)
      0:       startA = 1'b1;
      1:       startB = 1'b1;
      default: startC = 1'b1;
    endcase
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
  endtask

  // Count edges from the accepting edge until valid, watching that ready stays low while busy.
  task automatic waitValid(input string tag, input int expLat);
    int lat = 0;
    bit busyBad = 1'b0;
    checkOutput({tag, "_validDrops"}, 36'(obsValid), 36'd0);
    while (!obsValid && lat < 200) begin
      if (obsReady) busyBad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 36'(lat), 36'(expLat));
    checkOutput({tag, "_busyReady"}, 36'(busyBad), 36'd0);
    checkOutput({tag, "_readyInValid"}, 36'(obsReady), 36'd1);
  endtask

  task automatic runOp(input string tag, input int which, input logic s,
                       input logic [35:0] a, input logic [35:0] b, input int expLat,
                       input logic [35:0] expQ, input logic [35:0] expR,
                       input logic expDz, input logic expOv);
    applyStimulus(tag, which, s, a, b);
    waitValid(tag, expLat);
    checkResult(tag, expQ, expR, expDz, expOv);
  endtask

  // Directed sequence; successive runOp calls issue in the previous valid cycle.
  initial begin
    int lat;
    int seen;
    bit busyBad;
    sel = 0;
    reset = 1'b1;
    sign = 1'b0;
    dividend = '0;
    divider = '0;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      checkOutput("reset_ready", 36'(obsReady), 36'd1);
      checkOutput("reset_valid", 36'(obsValid), 36'd0);
      checkResult("reset", 36'd0, 36'd0, 1'b0, 1'b0);
    end

    $display("[TB] 36-bit, one bit per cycle");
    runOp("a_signed",   0, 1'b1, 36'hFEB7AFAA0, 36'hFFFFFFEE2, 37, 36'h000125E01, 36'hFFFFFFFBE, 1'b0, 1'b0);
    runOp("a_unsigned", 0, 1'b0, 36'hFFFFFFFFF, 36'h000000010, 37, 36'h0FFFFFFFF, 36'h00000000F, 1'b0, 1'b0);
    runOp("a_divzero",  0, 1'b1, 36'h123456789, 36'h000000000, 1,  36'hFFFFFFFFF, 36'h123456789, 1'b1, 1'b0);

    $display("[TB] 8-bit, one bit per cycle");
    runOp("b_u200d7",      1, 1'b0, 36'hC8, 36'h07, 9, 36'h1C, 36'h04, 1'b0, 1'b0);
    runOp("b_sm56d7",      1, 1'b1, 36'hC8, 36'h07, 9, 36'hF8, 36'h00, 1'b0, 1'b0);
    runOp("b_overflow",    1, 1'b1, 36'h80, 36'hFF, 9, 36'h80, 36'h00, 1'b0, 1'b1);
    runOp("b_divzero",     1, 1'b1, 36'h64, 36'h00, 1, 36'hFF, 36'h64, 1'b1, 1'b0);
    runOp("b_sm7d2",       1, 1'b1, 36'hF9, 36'h02, 9, 36'hFD, 36'hFF, 1'b0, 1'b0);
    runOp("b_s7dm2",       1, 1'b1, 36'h07, 36'hFE, 9, 36'hFD, 36'h01, 1'b0, 1'b0);
    runOp("b_u128d255",    1, 1'b0, 36'h80, 36'hFF, 9, 36'h00, 36'h80, 1'b0, 1'b0);
    runOp("b_smind1",      1, 1'b1, 36'h80, 36'h01, 9, 36'h80, 36'h00, 1'b0, 1'b0);
    runOp("b_divzero_neg", 1, 1'b1, 36'h80, 36'h00, 1, 36'hFF, 36'h80, 1'b1, 1'b0);
    runOp("b_u255d1",      1, 1'b0, 36'hFF, 36'h01, 9, 36'hFF, 36'h00, 1'b0, 1'b0);

    $display("[TB] 36-bit, four bits per cycle");
    runOp("c_u_all1d3",  2, 1'b0, 36'hFFFFFFFFF, 36'h000000003, 10, 36'h555555555, 36'h000000000, 1'b0, 1'b0);
    runOp("c_sm100d7",   2, 1'b1, 36'hFFFFFFF9C, 36'h000000007, 10, 36'hFFFFFFFF2, 36'hFFFFFFFFE, 1'b0, 1'b0);
    runOp("c_overflow",  2, 1'b1, 36'h800000000, 36'hFFFFFFFFF, 10, 36'h800000000, 36'h000000000, 1'b0, 1'b1);
    runOp("c_u_mind7",   2, 1'b0, 36'h800000000, 36'h000000007, 10, 36'h124924924, 36'h000000004, 1'b0, 1'b0);

    $display("[TB] reset in the middle of an operation");
    applyStimulus("b_rst", 1, 1'b0, 36'hC8, 36'h07);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("b_rst_ready", 36'(obsReady), 36'd1);
    checkOutput("b_rst_valid", 36'(obsValid), 36'd0);
    checkResult("b_rst", 36'd0, 36'd0, 1'b0, 1'b0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (obsValid) seen++;
    end
    checkOutput("b_rst_staleValid", 36'(seen), 36'd0);
    runOp("b_after_rst", 1, 1'b1, 36'hF9, 36'h02, 9, 36'hFD, 36'hFF, 1'b0, 1'b0);

    $display("[TB] start held high while busy");
    sel = 1;
    sign = 1'b0;
    dividend = 36'h64;
    divider = 36'h07;
    startB = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    busyBad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (obsReady) busyBad = 1'b1;
      dividend = 36'(k * 3 + 1);
      divider = 36'(k + 2);
      @(posedge clk); #1;
      lat++;
    end
    startB = 1'b0;
    while (!obsValid && lat < 200) begin
      if (obsReady) busyBad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b_held_latency", 36'(lat), 36'd9);
    checkOutput("b_held_busyReady", 36'(busyBad), 36'd0);
    checkResult("b_held", 36'h0E, 36'h02, 1'b0, 1'b0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (obsValid) seen++;
    end
    checkOutput("b_held_extraValid", 36'(seen), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
